// File: rtl/mux_2_1.sv
// mux_2_1: two-slave AXI-Stream mux feeding a registered 2-entry skid buffer.
// Define MUX_PKT_LOCK_EN to hold the selected source until a packet's last beat is accepted.
module mux_2_1 #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_data_1,
  input  logic                  s_valid_1,
  output logic                  s_ready_1,
  input  logic                  s_last_1,
  input  logic [DATA_WIDTH-1:0] s_data_2,
  input  logic                  s_valid_2,
  output logic                  s_ready_2,
  input  logic                  s_last_2,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t in_beat_c;
  logic  main_vld_q, main_vld_d;
  logic  skid_vld_q, skid_vld_d;
  logic  rdy1_q, rdy1_d;
  logic  rdy2_q, rdy2_d;
  logic  act_q, act_d;
  logic  in_fire_c;
  logic  out_fire_c;
`ifdef MUX_PKT_LOCK_EN
  logic  lock_q, lock_d;
`endif

  // A ready flop is only ever set for the active slave, so act_q alone steers the data.
  assign in_fire_c      = (s_valid_1 & rdy1_q) | (s_valid_2 & rdy2_q);
  assign out_fire_c     = main_vld_q & m_ready;
  assign in_beat_c.last = act_q ? s_last_2 : s_last_1;
  assign in_beat_c.data = act_q ? s_data_2 : s_data_1;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    act_d      = act_q;
`ifdef MUX_PKT_LOCK_EN
    lock_d     = lock_q;
`endif

    if (skid_vld_q) begin
      // Ready is low while the skid holds a beat, so only the drain side can move.
      if (out_fire_c) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_fire_c) begin
      if (!main_vld_q || out_fire_c) begin
        main_d     = in_beat_c;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat_c;
        skid_vld_d = 1'b1;
      end
    end else if (out_fire_c) begin
      main_vld_d = 1'b0;
    end

`ifdef MUX_PKT_LOCK_EN
    if (in_fire_c) begin
      lock_d = ~in_beat_c.last;
    end
    act_d = lock_d ? act_q : sel;
`else
    act_d = sel;
`endif

    rdy1_d = ~skid_vld_d & ~act_d;
    rdy2_d = ~skid_vld_d &  act_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy1_q     <= 1'b0;
      rdy2_q     <= 1'b0;
      act_q      <= 1'b0;
`ifdef MUX_PKT_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      act_q      <= act_d;
`ifdef MUX_PKT_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign m_data    = main_q.data;
  assign m_last    = main_q.last;
  assign m_valid   = main_vld_q;
  assign s_ready_1 = rdy1_q;
  assign s_ready_2 = rdy2_q;

endmodule

// File: tb/tb_mux_2_1.sv
// tb_mux_2_1: directed tables, packet-lock sequence and random traffic against a queue model.
module tb_mux_2_1;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic          sel;
  logic [DW-1:0] s_data_1, s_data_2, m_data;
  logic          s_valid_1, s_ready_1, s_last_1;
  logic          s_valid_2, s_ready_2, s_last_2;
  logic          m_valid, m_ready, m_last;

  mux_2_1 #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .sel(sel),
    .s_data_1(s_data_1), .s_valid_1(s_valid_1), .s_ready_1(s_ready_1), .s_last_1(s_last_1),
    .s_data_2(s_data_2), .s_valid_2(s_valid_2), .s_ready_2(s_ready_2), .s_last_2(s_last_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: content of the mux = FIFO of accepted-but-not-delivered beats (max 2).
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } bt_t;

  bt_t  q[$];
  logic started, act_m, open_m;
  logic pv, pa1, pa2, pof, psel;
  bt_t  pb1, pb2;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      started = 1'b0; act_m = 1'b0; open_m = 1'b0; pv = 1'b0;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_s_ready_1", 32'(s_ready_1), 32'd0);
      chk("rst_s_ready_2", 32'(s_ready_2), 32'd0);
    end else begin
      if (pv) begin
        if (pof && q.size() > 0) void'(q.pop_front());
        if (pa1) q.push_back(pb1);
        if (pa2) q.push_back(pb2);
`ifdef MUX_PKT_LOCK_EN
        if (pa1) open_m = ~pb1.last;
        if (pa2) open_m = ~pb2.last;
        if (!open_m) act_m = psel;
`else
        act_m = psel;
`endif
        started = 1'b1;
      end
      chk("mdl_m_valid", 32'(m_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("mdl_m_data", 32'(m_data), 32'(q[0].data));
        chk("mdl_m_last", 32'(m_last), 32'(q[0].last));
      end
      chk("mdl_s_ready_1", 32'(s_ready_1), 32'(started && !act_m && q.size() < 2));
      chk("mdl_s_ready_2", 32'(s_ready_2), 32'(started && act_m && q.size() < 2));
      pv   = 1'b1;
      pa1  = s_valid_1 && s_ready_1;
      pa2  = s_valid_2 && s_ready_2;
      pof  = m_valid && m_ready;
      psel = sel;
      pb1  = '{last: s_last_1, data: s_data_1};
      pb2  = '{last: s_last_2, data: s_data_2};
    end
  end

  typedef struct {
    logic          mr;
    logic          v1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
    logic          er;
  } vec_t;

  function automatic vec_t mkv(input logic mr, input logic v1, input logic [DW-1:0] d1,
                               input logic l1, input logic ev, input logic [DW-1:0] ed,
                               input logic el, input logic er);
    vec_t v;
    v.mr = mr; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ev = ev; v.ed = ed; v.el = el; v.er = er;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0; sel = 1'b0; m_ready = 1'b0;
    s_valid_1 = 1'b0; s_data_1 = '0; s_last_1 = 1'b0;
    s_valid_2 = 1'b0; s_data_2 = '0; s_last_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // 5-beat slave-1 packet with sel flipped while beat 3 is offered; slave 2 always has data.
  task automatic run_pkt();
    logic [DW-1:0] exp_d[7];
    logic          exp_l[7];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            idx1 = 0;
    int            idx2 = 0;
    logic          a1, a2;
`ifdef MUX_PKT_LOCK_EN
    exp_d = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'hA1, 8'hA2};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_d = '{8'h51, 8'h52, 8'h53, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 40 && got_d.size() < 7; c++) begin
      s_valid_1 = (idx1 < 5);
      s_data_1  = DW'(32'h51 + 32'(idx1));
      s_last_1  = (idx1 == 4);
      if (idx1 >= 2) sel = 1'b1;
      s_valid_2 = 1'b1;
      s_data_2  = DW'(32'hA1 + 32'(idx2));
      s_last_2  = 1'b0;
      @(negedge clk);
      a1 = s_valid_1 && s_ready_1;
      a2 = s_valid_2 && s_ready_2;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      @(posedge clk);
      #1;
      if (a1) idx1++;
      if (a2) idx2++;
    end
    chk("pkt_beat_count", 32'(got_d.size()), 32'd7);
    for (int i = 0; i < 7 && i < got_d.size(); i++) begin
      chk($sformatf("pkt_data%0d", i), 32'(got_d[i]), 32'(exp_d[i]));
      chk($sformatf("pkt_last%0d", i), 32'(got_l[i]), 32'(exp_l[i]));
    end
  endtask

  initial begin
    vec_t vt[13];
    vt[0]  = mkv(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    vt[1]  = mkv(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    vt[2]  = mkv(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
    vt[3]  = mkv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    vt[4]  = mkv(1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
    vt[5]  = mkv(1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    vt[6]  = mkv(1'b0, 1'b1, 8'h42, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    vt[7]  = mkv(1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
    vt[8]  = mkv(1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    vt[9]  = mkv(1'b1, 1'b1, 8'h43, 1'b0, 1'b1, 8'h43, 1'b0, 1'b1);
    vt[10] = mkv(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
    vt[11] = mkv(1'b1, 1'b1, 8'h45, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
    vt[12] = mkv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset held with slave 1 already offering data.
    reset = 1'b0; sel = 1'b0; m_ready = 1'b0;
    s_valid_1 = 1'b1; s_data_1 = 8'h77; s_last_1 = 1'b0;
    s_valid_2 = 1'b1; s_data_2 = 8'hAA; s_last_2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("inrst_m_valid", 32'(m_valid), 32'd0);
    chk("inrst_m_data", 32'(m_data), 32'd0);
    chk("inrst_m_last", 32'(m_last), 32'd0);
    chk("inrst_s_ready_1", 32'(s_ready_1), 32'd0);
    chk("inrst_s_ready_2", 32'(s_ready_2), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_s_ready_1", 32'(s_ready_1), 32'd1);
    chk("rel_s_ready_2", 32'(s_ready_2), 32'd0);
    chk("rel_m_valid", 32'(m_valid), 32'd0);

    // Streaming, then stall pattern 1,0,0,1,1,1,1,1 with slave 2 offering data it must never pass.
    for (int i = 0; i < 13; i++) begin
      m_ready = vt[i].mr; s_valid_1 = vt[i].v1; s_data_1 = vt[i].d1; s_last_1 = vt[i].l1;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(vt[i].ed));
        chk($sformatf("tbl%0d_m_last", i), 32'(m_last), 32'(vt[i].el));
      end
      chk($sformatf("tbl%0d_s_ready_1", i), 32'(s_ready_1), 32'(vt[i].er));
      chk($sformatf("tbl%0d_s_ready_2", i), 32'(s_ready_2), 32'd0);
    end

    // Reset while a beat is stalled on the master.
    do_reset();
    @(posedge clk);
    #1;
    s_valid_1 = 1'b1; s_data_1 = 8'h99; s_last_1 = 1'b1;
    @(posedge clk);
    #1;
    s_valid_1 = 1'b0;
    chk("stall_m_valid", 32'(m_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 32'd0);
    chk("async_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d_m_valid", i), 32'(m_valid), 32'd0);
    end

    run_pkt();

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) sel = ~sel;
      s_valid_1 = ($urandom_range(9) < 6);
      s_data_1  = DW'($urandom);
      s_last_1  = ($urandom_range(3) == 0);
      s_valid_2 = ($urandom_range(9) < 6);
      s_data_2  = DW'($urandom);
      s_last_2  = ($urandom_range(3) == 0);
      m_ready   = ($urandom_range(9) < 7);
      @(posedge clk);
      #1;
    end
    s_valid_1 = 1'b0; s_valid_2 = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_m_valid", 32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_2_1.md
MUX_2_1 -- requirements
Module: mux_2_1

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of every data bus.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sel, input, 1 bit: source select, 0 = slave 1, 1 = slave 2.
REQ-005 The block SHALL have ports s_data_1 (input, DATA_WIDTH), s_valid_1 (input, 1), s_ready_1 (output, 1) and s_last_1 (input, 1): AXI-Stream slave 1.
REQ-006 The block SHALL have ports s_data_2 (input, DATA_WIDTH), s_valid_2 (input, 1), s_ready_2 (output, 1) and s_last_2 (input, 1): AXI-Stream slave 2.
REQ-007 The block SHALL have ports m_data (output, DATA_WIDTH), m_valid (output, 1), m_ready (input, 1) and m_last (output, 1): AXI-Stream master.

Function
REQ-008 A beat SHALL transfer on any interface on a rising clk edge where valid and ready are both 1.
REQ-009 The active source (act) SHALL be an internal register; only the active slave may see ready = 1; the inactive slave's ready SHALL be 0.
REQ-010 The output SHALL be registered with a 2-entry skid buffer (main register + skid register); m_data, m_valid and m_last SHALL come straight from flops.
REQ-011 A beat accepted on the active slave SHALL appear on the master one cycle later (latency 1) when the buffer is empty.
REQ-012 s_ready of the active slave SHALL be 1 exactly when the skid register is empty; it SHALL be registered, with no combinational path from m_ready.
REQ-013 When m_ready = 0 with the main register full and a beat is accepted, that beat SHALL go into the skid register and ready SHALL drop on the next cycle.
REQ-014 When m_ready = 1 with the skid register full, the skid register SHALL move into the main register and ready SHALL rise on the next cycle.
REQ-015 When a master transfer and a slave transfer happen in the same cycle, the new beat SHALL load the main register and m_valid SHALL stay 1; no bubble, no loss, no duplication.
REQ-016 m_data and m_last SHALL hold stable while m_valid = 1 and m_ready = 0.
REQ-017 Beats SHALL leave in the exact order accepted, with s_last copied to m_last per beat.
REQ-018 s_data and s_last of the inactive slave SHALL never reach the master.
REQ-019 Changes on s_data or s_last while s_valid = 0 SHALL have no effect.

Reset
REQ-020 While reset = 0, m_valid, m_last, m_data, s_ready_1 and s_ready_2 SHALL all be 0, both buffer entries SHALL be empty, and act SHALL be 0.
REQ-021 Reset assertion SHALL take effect immediately without a clock edge; all in-flight beats SHALL be discarded.
REQ-022 On the first clk edge after reset deasserts, act SHALL load sel and the active slave's ready SHALL go to 1.

Configuration
REQ-023 Macro MUX_PKT_LOCK_EN, when defined, SHALL lock act for the duration of a packet.
REQ-024 With MUX_PKT_LOCK_EN defined, act SHALL load sel only while idle; idle is after reset or in the cycle after a beat with s_last = 1 is accepted on the active slave.
REQ-025 With MUX_PKT_LOCK_EN defined, a sel change in mid-packet SHALL be ignored until that packet's last beat is accepted.
REQ-026 With MUX_PKT_LOCK_EN undefined, act SHALL load sel every clk edge; beats already buffered SHALL still drain in order.

Verification
REQ-027 Reset held low, then released with sel = 0 and s_valid_1 = 1 -> all outputs 0 during reset; s_ready_1 = 1 and s_ready_2 = 0 one cycle after release.
REQ-028 sel = 0, m_ready = 1, s_valid_1 = 1 with data 0x11, 0x22, 0x33 -> m_data shows 0x11, 0x22, 0x33 on consecutive cycles with 1-cycle latency; slave 2 data never appears.
REQ-029 m_ready pattern 1,0,0,1,1,1,1,1 with s_valid_1 held at 1 -> s_ready_1 drops for the stall, no beat is lost or duplicated, and m_data is stable during the stall.
REQ-030 MUX_PKT_LOCK_EN defined; sel toggles 0 -> 1 during the 3rd beat of a 5-beat slave-1 packet (s_last_1 on beat 5) -> all 5 beats come from slave 1, m_last = 1 on beat 5, then slave 2 beats follow.
REQ-031 MUX_PKT_LOCK_EN undefined, same stimulus as REQ-030 -> slave-2 beats follow the sel change within 1 cycle; already buffered slave-1 beats still emerge first.
REQ-032 Reset asserted while m_valid = 1 and m_ready = 0 -> m_valid goes to 0 at once, without a clk edge; that beat never appears after reset.
